// File: rtl/id_scoreboard_bypass_if.sv
// ID-stage operand hazard bundle: sources, destination, forwarding ports, retire/flush, resolved operands.
// The master drives the ID-stage view and the slave (scoreboard) returns operands, stall, issue and perf counts.
interface id_scoreboard_bypass_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int NFWD = 3
);
  logic                 id_valid;
  logic                 ex_allowin;
  logic [NSRC-1:0]      src_en;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC*XLEN-1:0] rf_rdata;
  logic                 dst_we;
  logic [AW-1:0]        dst_addr;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD-1:0]      fwd_data_ok;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wb_retire;
  logic [AW-1:0]        wb_addr;
  logic                 flush_all;
  logic [NSRC*XLEN-1:0] src_value;
  logic                 stall;
  logic                 issue;
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_issue_cnt;

  modport master (
    output id_valid, ex_allowin, src_en, src_addr, rf_rdata, dst_we, dst_addr,
           fwd_valid, fwd_addr, fwd_data_ok, fwd_data, wb_retire, wb_addr, flush_all,
    input  src_value, stall, issue, perf_stall_cnt, perf_issue_cnt
  );

  modport slave (
    input  id_valid, ex_allowin, src_en, src_addr, rf_rdata, dst_we, dst_addr,
           fwd_valid, fwd_addr, fwd_data_ok, fwd_data, wb_retire, wb_addr, flush_all,
    output src_value, stall, issue, perf_stall_cnt, perf_issue_cnt
  );
endinterface

// File: rtl/id_scoreboard_bypass.sv
// ID operand resolve (0-cycle) with per-register pending-write scoreboard updated at the next edge; stall gates issue.
// Optional SB_PERF_CNT_EN adds 32-bit stall/issue counters, otherwise those outputs are tied to 0.
module id_scoreboard_bypass #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int NFWD  = 3,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  id_scoreboard_bypass_if.slave sb
);

  localparam int NREG = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     pend     [NREG];
  logic [CNT_W-1:0]     pend_nxt [NREG];
  logic [NSRC-1:0]      hazard;
  logic [NSRC*XLEN-1:0] src_value_w;
  logic                 sat_stall;
  logic                 stall_w;
  logic                 issue_w;
  logic                 inc;
  logic                 dec;

  // Lowest-numbered matching port is the youngest producer, so it wins; scan oldest first and overwrite.
  always_comb begin : resolve
    logic [AW-1:0]   a;
    logic            hit;
    logic            hit_ok;
    logic [XLEN-1:0] hit_dat;
    src_value_w = '0;
    hazard      = '0;
    a           = '0;
    hit         = 1'b0;
    hit_ok      = 1'b0;
    hit_dat     = '0;
    for (int i = 0; i < NSRC; i++) begin
      a       = sb.src_addr[i*AW +: AW];
      hit     = 1'b0;
      hit_ok  = 1'b0;
      hit_dat = '0;
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (sb.fwd_valid[k] && (sb.fwd_addr[k*AW +: AW] == a)) begin
          hit     = 1'b1;
          hit_ok  = sb.fwd_data_ok[k];
          hit_dat = sb.fwd_data[k*XLEN +: XLEN];
        end
      end
      if (a == '0) begin
        src_value_w[i*XLEN +: XLEN] = '0;
      end else if (hit) begin
        if (hit_ok) begin
          src_value_w[i*XLEN +: XLEN] = hit_dat;
        end else begin
          src_value_w[i*XLEN +: XLEN] = sb.rf_rdata[i*XLEN +: XLEN];
          hazard[i] = 1'b1;
        end
      end else begin
        // A pending write with no forwarding port means the producer sits in a non-forwarding stage.
        src_value_w[i*XLEN +: XLEN] = sb.rf_rdata[i*XLEN +: XLEN];
        if (pend[a] != '0) begin
          hazard[i] = 1'b1;
        end
      end
    end
  end

  assign sat_stall = sb.dst_we && (sb.dst_addr != '0) && (pend[sb.dst_addr] == CNT_MAX);
  assign stall_w   = sb.id_valid && ((|(hazard & sb.src_en)) || sat_stall);
  assign issue_w   = sb.id_valid && sb.ex_allowin && !stall_w;
  assign inc       = issue_w && sb.dst_we && (sb.dst_addr != '0);
  assign dec       = sb.wb_retire && (sb.wb_addr != '0);

  assign sb.src_value = src_value_w;
  assign sb.stall     = stall_w;
  assign sb.issue     = issue_w;

  always_comb begin : pend_next
    for (int r = 0; r < NREG; r++) begin
      pend_nxt[r] = pend[r];
    end
    if (sb.flush_all) begin
      // Squash drops every in-flight writer and the retire; the instruction issuing now survives.
      for (int r = 0; r < NREG; r++) begin
        pend_nxt[r] = '0;
      end
      if (inc) begin
        pend_nxt[sb.dst_addr] = CNT_W'(1);
      end
    end else if (!(inc && dec && (sb.dst_addr == sb.wb_addr))) begin
      if (inc) begin
        pend_nxt[sb.dst_addr] = pend[sb.dst_addr] + CNT_W'(1);
      end
      if (dec && (pend[sb.wb_addr] != '0)) begin
        pend_nxt[sb.wb_addr] = pend[sb.wb_addr] - CNT_W'(1);
      end
    end
    pend_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= pend_nxt[r];
      end
    end
  end

`ifdef SB_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;

  // Free-running wrap; flush_all leaves these alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_w) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (issue_w) begin
        issue_cnt <= issue_cnt + 32'd1;
      end
    end
  end

  assign sb.perf_stall_cnt = stall_cnt;
  assign sb.perf_issue_cnt = issue_cnt;
`else
  assign sb.perf_stall_cnt = '0;
  assign sb.perf_issue_cnt = '0;
`endif

endmodule
